// File: rtl/ad_clock_125m_gen.sv
`timescale 1ns/100ps
// ad_clock_125m_gen
// Qualifies a reference clock (clkin1) against a fast timebase (clk_tb) and,
// once the reference has shown LOCK_COUNT consecutive in-tolerance periods,
// emits a divided clock (clk_tb / OUT_DIV) and a lock indicator.
//
// Ports:
//   clk_tb   in   timebase clock, every register is on its rising edge
//   rst_n    in   asynchronous active-low reset
//   clkin1   in   reference clock, asynchronous to clk_tb
//   clkout0  out  clk_tb / OUT_DIV, 50% duty, held low while unlocked
//   pll_lock out  registered lock indicator
module ad_clock_125m_gen #(
  parameter int CLKIN_NOM  = 10,
  parameter int CLKIN_TOL  = 1,
  parameter int LOCK_COUNT = 64,
  parameter int OUT_DIV    = 4,
  parameter int CNT_W      = 8
) (
  input  logic clk_tb,
  input  logic rst_n,
  input  logic clkin1,
  output logic clkout0,
  output logic pll_lock
);

  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int DIV_W  = (OUT_DIV > 2) ? $clog2(OUT_DIV) : 1;
  localparam int PER_LO = (CLKIN_NOM > CLKIN_TOL) ? (CLKIN_NOM - CLKIN_TOL) : 0;
  localparam int PER_HI = CLKIN_NOM + CLKIN_TOL;

  localparam logic [CNT_W-1:0]  PER_LO_C = CNT_W'(PER_LO);
  localparam logic [CNT_W-1:0]  PER_HI_C = CNT_W'(PER_HI);
  localparam logic [CNT_W-1:0]  PER_MAX  = '1;
  localparam logic [GOOD_W-1:0] LOCK_C   = GOOD_W'(LOCK_COUNT);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(OUT_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_HALF = DIV_W'(OUT_DIV / 2);

  logic              sync1, sync2, sync3;
  logic              clkin_rise;
  logic [CNT_W-1:0]  per_cnt;
  logic              first_seen;
  logic [GOOD_W-1:0] good_cnt;
  logic [DIV_W-1:0]  div_cnt;

  logic              period_ok;
  logic              good_edge;
  logic              bad_event;
  logic              lock_next;
  logic [DIV_W-1:0]  div_next;
  logic              clk_next;

  // Two synchroniser flops, the third only remembers the previous level.
  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= clkin1;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign clkin_rise = sync2 & ~sync3;

  // per_cnt holds the length of the current reference period; on a rise it
  // is the measured period and restarts at 1.
  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt    <= '0;
      first_seen <= 1'b0;
    end else begin
      if (clkin_rise) begin
        per_cnt    <= CNT_W'(1);
        first_seen <= 1'b1;
      end else if (per_cnt != PER_MAX) begin
        per_cnt <= per_cnt + CNT_W'(1);
      end
    end
  end

  assign period_ok = (per_cnt >= PER_LO_C) && (per_cnt <= PER_HI_C);

  // The first rise after reset has no valid start point, so it is not judged.
  // Without a rise, a period that has already run past the upper bound is a
  // stopped reference and counts as bad on every cycle until a rise arrives.
  always_comb begin
    good_edge = 1'b0;
    bad_event = 1'b0;
    if (clkin_rise) begin
      if (first_seen) begin
        good_edge = period_ok;
        bad_event = ~period_ok;
      end
    end else if (first_seen && (per_cnt > PER_HI_C)) begin
      bad_event = 1'b1;
    end
  end

  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) begin
      good_cnt <= '0;
    end else if (bad_event) begin
      good_cnt <= '0;
    end else if (good_edge && (good_cnt != LOCK_C)) begin
      good_cnt <= good_cnt + GOOD_W'(1);
    end
  end

  // A bad event wins over a saturated good count in the same cycle.
  always_comb begin
    lock_next = pll_lock;
    if (bad_event) begin
      lock_next = 1'b0;
    end else if (good_cnt == LOCK_C) begin
      lock_next = 1'b1;
    end
  end

  // The divider only runs while locked, so the first high phase always starts
  // one cycle after lock rises.
  always_comb begin
    div_next = '0;
    if (pll_lock) begin
      div_next = (div_cnt == DIV_LAST) ? '0 : (div_cnt + DIV_W'(1));
    end
    clk_next = pll_lock && (div_cnt < DIV_HALF);
  end

  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) begin
      pll_lock <= 1'b0;
      div_cnt  <= '0;
      clkout0  <= 1'b0;
    end else begin
      pll_lock <= lock_next;
      div_cnt  <= div_next;
      clkout0  <= clk_next;
    end
  end

endmodule

// File: tb/tb_ad_clock_125m_gen.sv
`timescale 1ns/100ps
// tb_ad_clock_125m_gen
// Drives clkin1 with randomised in-tolerance periods, stopped, slow and
// single-short-period patterns, and compares pll_lock/clkout0 every cycle
// against an event-level model: lock holds when at least 64 good periods
// were seen since the last bad event (and none occurs now); clkout0 follows
// the phase of the current locked run.
module tb_ad_clock_125m_gen;

  localparam int NOM   = 10;
  localparam int TOL   = 1;
  localparam int LOCKN = 64;
  localparam int DIV   = 4;

  logic clk_tb;
  logic rst_n;
  logic clkin1;
  logic clkout0;
  logic pll_lock;

  ad_clock_125m_gen #(
    .CLKIN_NOM (NOM),
    .CLKIN_TOL (TOL),
    .LOCK_COUNT(LOCKN),
    .OUT_DIV   (DIV),
    .CNT_W     (8)
  ) dut (
    .clk_tb  (clk_tb),
    .rst_n   (rst_n),
    .clkin1  (clkin1),
    .clkout0 (clkout0),
    .pll_lock(pll_lock)
  );

  // ---------------- clock ----------------
  initial begin
    clk_tb = 1'b0;
    forever #1 clk_tb = ~clk_tb;
  end

  // ---------------- reference generator ----------------
  // gen_mode: 0 stopped low, 1 random 9..11 cycles, 2 fixed 14 cycles.
  // clkin1 changes on negedges so its sampling on posedges is unambiguous.
  int gen_mode;
  int short_req;
  int short_done;

  initial begin
    int p;
    clkin1     = 1'b0;
    short_done = 0;
    forever begin
      if (gen_mode == 0) begin
        clkin1 = 1'b0;
        @(negedge clk_tb);
      end else begin
        if (short_req != short_done) begin
          p = 5;
          short_done = short_done + 1;
        end else if (gen_mode == 2) begin
          p = 14;
        end else begin
          p = int'($urandom_range(NOM + TOL, NOM - TOL));
        end
        clkin1 = 1'b1;
        repeat (p / 2) @(negedge clk_tb);
        clkin1 = 1'b0;
        repeat (p - p / 2) @(negedge clk_tb);
      end
    end
  end

  // ---------------- reference model + scoreboard ----------------
  logic [1:0]  exp_q[$];
  int unsigned pend_q[$];
  int unsigned good_q[$];
  int unsigned m_cyc;
  int unsigned last_edge;
  int unsigned lock_run;
  logic        prev_s;
  logic        first_seen_m;
  logic        m_lock;
  logic        m_clk;

  int n_cmp;
  int n_fail;
  int obs_rises;
  int obs_falls;
  logic last_lock;

  task automatic model_step(input logic s, input logic rn);
    logic        edge_now;
    logic        good;
    logic        bad;
    logic        prev_lock;
    int unsigned per;
    if (rn !== 1'b1) begin
      m_cyc        = 0;
      pend_q.delete();
      good_q.delete();
      prev_s       = 1'b0;
      first_seen_m = 1'b0;
      last_edge    = 0;
      m_lock       = 1'b0;
      m_clk        = 1'b0;
      lock_run     = 0;
      exp_q.push_back(2'b00);
    end else begin
      m_cyc = m_cyc + 1;
      // A sampled rise takes effect two updates later (synchroniser latency).
      edge_now = 1'b0;
      if (pend_q.size() > 0 && pend_q[0] == m_cyc) begin
        void'(pend_q.pop_front());
        edge_now = 1'b1;
      end
      if (s && !prev_s) pend_q.push_back(m_cyc + 2);
      prev_s = s;

      good = 1'b0;
      bad  = 1'b0;
      if (edge_now) begin
        if (first_seen_m) begin
          per = m_cyc - last_edge;
          if (per >= NOM - TOL && per <= NOM + TOL) good = 1'b1;
          else bad = 1'b1;
        end
        first_seen_m = 1'b1;
        last_edge    = m_cyc;
      end else if (first_seen_m && (m_cyc - last_edge > NOM + TOL)) begin
        bad = 1'b1;
      end

      prev_lock = m_lock;
      if (bad) begin
        good_q.delete();
        m_lock = 1'b0;
      end else begin
        m_lock = (good_q.size() >= LOCKN);
        if (good) begin
          good_q.push_back(m_cyc);
          if (good_q.size() > LOCKN) void'(good_q.pop_front());
        end
      end

      if (prev_lock) lock_run = lock_run + 1;
      else lock_run = 0;
      m_clk = prev_lock && (((lock_run - 1) % DIV) < DIV / 2);
      exp_q.push_back({m_lock, m_clk});
    end
  endtask

  task automatic check_cycle();
    logic [1:0] e;
    e = exp_q.pop_front();
    n_cmp = n_cmp + 1;
    assert ({pll_lock, clkout0} === e) else begin
      n_fail = n_fail + 1;
      $error("FAIL cycle_chk cyc=%0d lock,clkout0 got=%b exp=%b", m_cyc, {pll_lock, clkout0}, e);
    end
    if (pll_lock === 1'b1 && last_lock === 1'b0) obs_rises = obs_rises + 1;
    if (pll_lock === 1'b0 && last_lock === 1'b1) obs_falls = obs_falls + 1;
    last_lock = pll_lock;
  endtask

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp = n_cmp + 1;
    assert (got === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_tb);
      model_step(clkin1, rst_n);
      #0.5;
      check_cycle();
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int guard;
    n_cmp     = 0;
    n_fail    = 0;
    obs_rises = 0;
    obs_falls = 0;
    last_lock = 1'b0;
    short_req = 0;
    gen_mode  = 1;
    rst_n     = 1'b0;

    // Reset held with clkin1 running: outputs must stay low.
    run_cycles(10);
    #0.2 rst_n = 1'b1;

    // Nominal reference: single lock rise, then stays locked.
    obs_rises = 0;
    run_cycles(3000);
    check_val("s2_single_rise", obs_rises, 1);
    check_val("s2_locked", int'(pll_lock), 1);

    // Reference stopped low: watchdog drops lock.
    gen_mode = 0;
    obs_falls = 0;
    run_cycles(200);
    check_val("s3_fall", obs_falls, 1);
    check_val("s3_unlocked", int'(pll_lock), 0);

    // Slow reference (14 cycles): never locks.
    gen_mode  = 2;
    obs_rises = 0;
    run_cycles(1500);
    check_val("s4_no_lock", obs_rises, 0);
    check_val("s4_clkout_low", int'(clkout0), 0);

    // Relock, then inject one short period.
    gen_mode = 1;
    run_cycles(1200);
    check_val("s5_pre_lock", int'(pll_lock), 1);
    obs_rises = 0;
    obs_falls = 0;
    short_req = short_req + 1;
    guard = 0;
    while (short_done != short_req && guard < 50) begin
      run_cycles(1);
      guard = guard + 1;
    end
    check_val("s5_inject_taken", short_done, short_req);
    run_cycles(1200);
    check_val("s5_drop", obs_falls, 1);
    check_val("s5_relock", obs_rises, 1);

    // Asynchronous reset while locked, then full relock.
    check_val("s6_pre_lock", int'(pll_lock), 1);
    rst_n = 1'b0;
    #0.2;
    check_val("s6_async_lock", int'(pll_lock), 0);
    check_val("s6_async_clk", int'(clkout0), 0);
    run_cycles(5);
    #0.2 rst_n = 1'b1;
    obs_rises = 0;
    run_cycles(1500);
    check_val("s6_relock", obs_rises, 1);
    check_val("s6_locked", int'(pll_lock), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ad_clock_125m_gen.md
Name: ad_clock_125m_gen

Overview:
- Clock-generation block for the ADC sample path.
- Qualifies a 50 MHz reference clock (clkin1) against a fast timebase clock (clk_tb, 500 MHz nominal).
- Produces a 125 MHz clock (clkout0 = clk_tb / 4) and a lock indicator (pll_lock).
- Models PLL lock behaviour in synthesizable RTL. It has no dependency on the vendor global set/reset primitive (GTP_GRS); that primitive is instanced at top level with GRS_N tied high.

Parameters:
- CLKIN_NOM, 10: nominal clkin1 period, in clk_tb cycles.
- CLKIN_TOL, 1: allowed period deviation (±), in clk_tb cycles.
- LOCK_COUNT, 64: consecutive good clkin1 periods required to assert lock.
- OUT_DIV, 4: clk_tb divide ratio for clkout0. Must be even and ≥ 2.
- CNT_W, 8: width of the period counter. The counter saturates at 2^CNT_W − 1.

Ports:
- clk_tb, input, 1: timebase clock; all logic is on its rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- clkin1, input, 1: reference clock (50 MHz nominal), asynchronous to clk_tb.
- clkout0, output, 1: generated clock, clk_tb / OUT_DIV, 50% duty. Held low while unlocked.
- pll_lock, output, 1: registered lock indicator.

Behaviour:

Reset:
- Interface: reset rst_n, asynchronous, active-low; clock clk_tb.
- While rst_n = 0, all registers clear: pll_lock = 0, clkout0 = 0, counters = 0, first_seen = 0.

Input synchronisation:
- clkin1 passes through a 2-flop synchroniser, followed by a third flop for edge detection.
- edge = sync2 & ~sync3. The edge is seen 3 clk_tb cycles after the clkin1 rise.

Period counter (per_cnt):
- On edge: per_cnt <= 1.
- Otherwise: per_cnt <= per_cnt + 1, saturating at the maximum value.
- The value of per_cnt in an edge cycle is the measured period. Example: a 20 ns clkin1 period at 500 MHz measures 10.

Edge qualification:
- First edge after reset only sets first_seen = 1; its period is not evaluated.
- Later edges are good if |per_cnt − CLKIN_NOM| ≤ CLKIN_TOL; otherwise they are bad.

Watchdog:
- When first_seen = 1, there is no edge, and per_cnt > CLKIN_NOM + CLKIN_TOL, that cycle is a bad event.
- This event repeats every cycle while clkin1 is stopped.
- An edge in the same cycle takes precedence; only the edge is evaluated.

good_cnt (width clog2(LOCK_COUNT+1)):
- Good edge: good_cnt increments, saturating at LOCK_COUNT.
- Bad event: good_cnt clears to 0.

Lock:
- pll_lock <= 1 on the cycle after good_cnt reaches LOCK_COUNT.
- pll_lock <= 0 on the cycle after any bad event.
- Lock is not re-asserted until LOCK_COUNT new consecutive good edges.
- With a stable input, pll_lock rises exactly once and never falls.

Output divider:
- div_cnt next = pll_lock ? (div_cnt == OUT_DIV − 1 ? 0 : div_cnt + 1) : 0.
- clkout0 next = pll_lock & (div_cnt < OUT_DIV / 2).
- clkout0 first rises 1 cycle after pll_lock rises. It is then high for OUT_DIV/2 cycles and low for OUT_DIV/2 cycles.
- On lock loss, clkout0 is forced low the next cycle; a truncated high phase is permitted.

Test Plan:
1. Reset held 20 ns with clkin1 running → pll_lock = 0 and clkout0 = 0 throughout reset.
2. clk_tb at 500 MHz, clkin1 at 50 MHz, reset released at 20 ns:
   - pll_lock rises once after 1 reference edge + 64 good edges (≈1.3 µs).
   - pll_lock stays high for 4 ms with no second rising edge.
   - clkout0 period 8 ns, high 4 ns, first rise 1 clk_tb cycle after pll_lock.
3. Lock achieved, then clkin1 held low → pll_lock falls 1 cycle after per_cnt reaches 12, and clkout0 is low the cycle after.
4. clkin1 period 28 ns (14 cycles) → pll_lock never asserts and clkout0 stays 0.
5. Lock achieved, then a single 10 ns clkin1 period (measured 5) injected:
   - pll_lock drops.
   - pll_lock re-asserts after exactly 64 subsequent good periods.
6. rst_n pulsed low while locked:
   - pll_lock and clkout0 go to 0 asynchronously.
   - After release, the full relock sequence of scenario 2 repeats.
